// File: rtl/boot_eoc_ctrl.sv
// Boot / end-of-computation controller.
// Samples the boot mode once after reset, then either waits for an idle-mode
// preload or issues an autonomous boot request. After that it repeatedly polls
// a scratch register over a single-outstanding read port until bit 0 reads as
// one, reporting the remaining 31 bits as the exit code. A global timeout and
// an illegal-mode check both end in a terminal error state.
module boot_eoc_ctrl #(
   parameter int          AddrWidth     = 64,
   parameter logic [63:0] ScratchAddr   = 64'h0300_0008,
   parameter int          PollCycles    = 16,
   parameter int          TimeoutCycles = 1_000_000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic [1:0]           boot_mode_i,
   input  logic                 preload_done_i,

   output logic                 boot_req_o,
   input  logic                 boot_ack_i,

   output logic                 rd_req_o,
   output logic [AddrWidth-1:0] rd_addr_o,
   input  logic                 rd_gnt_i,
   input  logic                 rd_rvalid_i,
   input  logic [31:0]          rd_rdata_i,

   output logic                 eoc_o,
   output logic [31:0]          exit_code_o,
   output logic                 mode_err_o,
   output logic                 timeout_o,
   output logic                 busy_o
);

   // Counter widths are just wide enough to hold their maximum value.
   localparam int PollW = $clog2(PollCycles + 1);
   localparam int TmoW  = $clog2(TimeoutCycles + 1);

   localparam logic [PollW-1:0]     POLL_LOAD = PollW'(PollCycles);
   localparam logic [PollW-1:0]     POLL_ONE  = PollW'(1);
   localparam logic [TmoW-1:0]      TMO_ONE   = TmoW'(1);
   localparam logic [TmoW-1:0]      TMO_LAST  = TmoW'(TimeoutCycles - 1);
   localparam logic [TmoW-1:0]      TMO_MAX   = TmoW'(TimeoutCycles);
   localparam logic [AddrWidth-1:0] SCRATCH   = AddrWidth'(ScratchAddr);

   typedef enum logic [2:0] {
      ST_SAMPLE       = 3'd0,
      ST_WAIT_PRELOAD = 3'd1,
      ST_BOOT_REQ     = 3'd2,
      ST_POLL_WAIT    = 3'd3,
      ST_POLL_REQ     = 3'd4,
      ST_POLL_RESP    = 3'd5,
      ST_DONE         = 3'd6,
      ST_ERROR        = 3'd7
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic              eoc_q, eoc_d;
   logic [31:0]       exit_code_q, exit_code_d;
   logic              mode_err_q, mode_err_d;
   logic              timeout_q, timeout_d;

   logic              tmo_active;
   logic              tmo_hit;
   logic              eoc_accept;

   // State register and all status/counter flops; reset abandons any transaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_SAMPLE;
         mode_q      <= 2'd0;
         poll_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         eoc_q       <= 1'b0;
         exit_code_q <= 32'd0;
         mode_err_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         poll_cnt_q  <= poll_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         eoc_q       <= eoc_d;
         exit_code_q <= exit_code_d;
         mode_err_q  <= mode_err_d;
         timeout_q   <= timeout_d;
      end
   end

   // Timeout bookkeeping: runs in every waiting state, saturates, and fires on
   // the last allowed cycle so the error state is entered right after it.
   always_comb begin
      tmo_active = (state_q == ST_WAIT_PRELOAD) || (state_q == ST_BOOT_REQ) ||
                   (state_q == ST_POLL_WAIT)    || (state_q == ST_POLL_REQ) ||
                   (state_q == ST_POLL_RESP);
      tmo_hit    = tmo_active && (tmo_cnt_q >= TMO_LAST);
      eoc_accept = (state_q == ST_POLL_RESP) && rd_rvalid_i && rd_rdata_i[0];
   end

   // Next-state and datapath updates; an accepted EOC response beats a
   // timeout landing in the same cycle.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      poll_cnt_d  = poll_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      eoc_d       = eoc_q;
      exit_code_d = exit_code_q;
      mode_err_d  = mode_err_q;
      timeout_d   = timeout_q;

      if (tmo_active && (tmo_cnt_q != TMO_MAX)) begin
         tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      end

      case (state_q)
         ST_SAMPLE: begin
            mode_d = boot_mode_i;
            case (boot_mode_i)
               2'd0: state_d = ST_WAIT_PRELOAD;
               2'd1: begin
                  state_d    = ST_ERROR;
                  mode_err_d = 1'b1;
               end
               default: state_d = ST_BOOT_REQ;
            endcase
         end
         ST_WAIT_PRELOAD: begin
            if (preload_done_i) begin
               state_d    = ST_POLL_WAIT;
               poll_cnt_d = POLL_LOAD;
            end
         end
         ST_BOOT_REQ: begin
            if (boot_ack_i) begin
               state_d    = ST_POLL_WAIT;
               poll_cnt_d = POLL_LOAD;
            end
         end
         ST_POLL_WAIT: begin
            if (poll_cnt_q <= POLL_ONE) begin
               state_d = ST_POLL_REQ;
            end else begin
               poll_cnt_d = poll_cnt_q - POLL_ONE;
            end
         end
         ST_POLL_REQ: begin
            if (rd_gnt_i) begin
               state_d = ST_POLL_RESP;
            end
         end
         ST_POLL_RESP: begin
            if (rd_rvalid_i) begin
               if (rd_rdata_i[0]) begin
                  state_d     = ST_DONE;
                  eoc_d       = 1'b1;
                  exit_code_d = {1'b0, rd_rdata_i[31:1]};
               end else begin
                  state_d    = ST_POLL_WAIT;
                  poll_cnt_d = POLL_LOAD;
               end
            end
         end
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_ERROR;
      endcase

      if (tmo_hit && !eoc_accept) begin
         state_d     = ST_ERROR;
         timeout_d   = 1'b1;
         exit_code_d = 32'hFFFF_FFFF;
      end
   end

   // Handshake and busy outputs decoded from the current state; only the
   // autonomous boot modes ever reach the boot request state.
   always_comb begin
      boot_req_o = 1'b0;
      rd_req_o   = 1'b0;
      busy_o     = 1'b1;
      case (state_q)
         ST_BOOT_REQ: boot_req_o = mode_q[1];
         ST_POLL_REQ: rd_req_o   = 1'b1;
         ST_DONE,
         ST_ERROR:    busy_o     = 1'b0;
         default:     busy_o     = 1'b1;
      endcase
   end

   assign rd_addr_o   = SCRATCH;
   assign eoc_o       = eoc_q;
   assign exit_code_o = exit_code_q;
   assign mode_err_o  = mode_err_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_boot_eoc_ctrl.sv
// Self-checking bench for boot_eoc_ctrl: a per-cycle vector table for the
// autonomous boot path plus directed sequences for the multi-cycle cases.
module tb_boot_eoc_ctrl;

   localparam int          AddrWidth     = 64;
   localparam logic [63:0] SCRATCH       = 64'h0300_0008;
   localparam int          PollCycles    = 4;
   localparam int          TimeoutCycles = 100;

   logic                 clk;
   logic                 rst;
   logic [1:0]           bootMode;
   logic                 preloadDone;
   logic                 bootReqO;
   logic                 bootAck;
   logic                 rdReqO;
   logic [AddrWidth-1:0] rdAddrO;
   logic                 rdGnt;
   logic                 rdRvalid;
   logic [31:0]          rdRdata;
   logic                 eocO;
   logic [31:0]          exitCodeO;
   logic                 modeErrO;
   logic                 timeoutO;
   logic                 busyO;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        rst;
      logic [1:0]  mode;
      logic        preload;
      logic        ack;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        expBootReq;
      logic        expRdReq;
      logic        expEoc;
      logic        expBusy;
      logic [31:0] expExit;
   } vec_t;

   vec_t vecs[14];

   boot_eoc_ctrl #(
      .AddrWidth     (AddrWidth),
      .ScratchAddr   (SCRATCH),
      .PollCycles    (PollCycles),
      .TimeoutCycles (TimeoutCycles)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .boot_mode_i    (bootMode),
      .preload_done_i (preloadDone),
      .boot_req_o     (bootReqO),
      .boot_ack_i     (bootAck),
      .rd_req_o       (rdReqO),
      .rd_addr_o      (rdAddrO),
      .rd_gnt_i       (rdGnt),
      .rd_rvalid_i    (rdRvalid),
      .rd_rdata_i     (rdRdata),
      .eoc_o          (eocO),
      .exit_code_o    (exitCodeO),
      .mode_err_o     (modeErrO),
      .timeout_o      (timeoutO),
      .busy_o         (busyO)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic r, input logic [1:0] m, input logic pre,
                                  input logic ak, input logic g, input logic rv,
                                  input logic [31:0] rd, input logic eBr, input logic eRr,
                                  input logic eEoc, input logic eBusy, input logic [31:0] eExit);
      vec_t v;
      v.rst = r; v.mode = m; v.preload = pre; v.ack = ak; v.gnt = g;
      v.rvalid = rv; v.rdata = rd;
      v.expBootReq = eBr; v.expRdReq = eRr; v.expEoc = eEoc;
      v.expBusy = eBusy; v.expExit = eExit;
      return v;
   endfunction

   task automatic stepCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst         = v.rst;
      bootMode    = v.mode;
      preloadDone = v.preload;
      bootAck     = v.ack;
      rdGnt       = v.gnt;
      rdRvalid    = v.rvalid;
      rdRdata     = v.rdata;
   endtask

   task automatic clearInputs();
      preloadDone = 1'b0;
      bootAck     = 1'b0;
      rdGnt       = 1'b0;
      rdRvalid    = 1'b0;
      rdRdata     = 32'd0;
   endtask

   // Leaves the bench at a falling edge with the DUT in SAMPLE (cycle 0).
   task automatic applyReset(input logic [1:0] mode);
      clearInputs();
      bootMode = mode;
      rst      = 1'b1;
      stepCycles(2);
      rst      = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bootMode = 2'd0;
      clearInputs();

      // Mode 2 path: ack three cycles into the request, grant-cycle rvalid
      // ignored, EOC data 7 gives exit code 3.
      vecs[0]  = mkVec(1, 2, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[1]  = mkVec(0, 2, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 32'h0);
      vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 32'h0);
      vecs[3]  = mkVec(0, 1, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 32'h0);
      vecs[4]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 32'h0);
      vecs[5]  = mkVec(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[9]  = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 32'h0);
      vecs[10] = mkVec(0, 0, 0, 0, 1, 1, 32'h1, 0, 0, 0, 1, 32'h0);
      vecs[11] = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      vecs[12] = mkVec(0, 0, 0, 0, 0, 1, 32'h7, 0, 0, 1, 0, 32'h3);
      vecs[13] = mkVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, 32'h3);

      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i),
                     {26'd0, bootReqO, rdReqO, eocO, busyO, exitCodeO},
                     {26'd0, vecs[i].expBootReq, vecs[i].expRdReq, vecs[i].expEoc,
                      vecs[i].expBusy, vecs[i].expExit});
      end
      clearInputs();

      // Mode 0: preload at cycle 10, polls return 0 then 1, mode pins toggled.
      begin
         int  grants;
         int  respIdx;
         logic pending;
         grants = 0; respIdx = 0; pending = 1'b0;
         applyReset(2'd0);
         checkOutput("rst_addr", rdAddrO, SCRATCH);
         checkOutput("rst_busy", {63'd0, busyO}, 64'd1);
         stepCycles(1);
         bootMode = 2'd1;
         stepCycles(9);
         preloadDone = 1'b1;
         stepCycles(1);
         preloadDone = 1'b0;
         bootMode = 2'd3;
         for (int c = 0; c < 60; c++) begin
            if (eocO) break;
            rdRvalid = pending;
            rdRdata  = (respIdx == 0) ? 32'h0 : 32'h1;
            if (pending) respIdx++;
            pending  = 1'b0;
            rdGnt    = rdReqO;
            if (rdReqO) begin
               grants++;
               pending = 1'b1;
            end
            stepCycles(1);
         end
         clearInputs();
         checkOutput("m0_eoc", {63'd0, eocO}, 64'd1);
         checkOutput("m0_exit", {32'd0, exitCodeO}, 64'd0);
         checkOutput("m0_busy", {63'd0, busyO}, 64'd0);
         checkOutput("m0_grants", 64'(grants), 64'd2);
         checkOutput("m0_moderr", {63'd0, modeErrO}, 64'd0);
      end

      // Mode 1: error right after SAMPLE, no requests ever raised.
      begin
         logic sawReq;
         sawReq = 1'b0;
         applyReset(2'd1);
         bootAck = 1'b1;
         rdGnt   = 1'b1;
         stepCycles(1);
         checkOutput("m1_moderr", {63'd0, modeErrO}, 64'd1);
         checkOutput("m1_busy", {63'd0, busyO}, 64'd0);
         for (int c = 0; c < 10; c++) begin
            if (bootReqO || rdReqO) sawReq = 1'b1;
            stepCycles(1);
         end
         checkOutput("m1_noreq", {63'd0, sawReq}, 64'd0);
         checkOutput("m1_tmo", {63'd0, timeoutO}, 64'd0);
         clearInputs();
      end

      // Mode 0 with no preload: timeout after the 100th waiting cycle.
      applyReset(2'd0);
      stepCycles(100);
      checkOutput("tmo_c100", {63'd0, timeoutO}, 64'd0);
      checkOutput("tmo_c100_busy", {63'd0, busyO}, 64'd1);
      stepCycles(1);
      checkOutput("tmo_c101", {63'd0, timeoutO}, 64'd1);
      checkOutput("tmo_exit", {32'd0, exitCodeO}, 64'hFFFF_FFFF);
      checkOutput("tmo_busy", {63'd0, busyO}, 64'd0);

      // Mode 2, EOC response in the very cycle the timeout expires: EOC wins.
      applyReset(2'd2);
      bootAck = 1'b1;
      rdGnt   = 1'b1;
      stepCycles(100);
      checkOutput("win_pre_eoc", {63'd0, eocO}, 64'd0);
      rdRvalid = 1'b1;
      rdRdata  = 32'h0000_000B;
      stepCycles(1);
      rdRvalid = 1'b0;
      checkOutput("win_eoc", {63'd0, eocO}, 64'd1);
      checkOutput("win_tmo", {63'd0, timeoutO}, 64'd0);
      checkOutput("win_exit", {32'd0, exitCodeO}, 64'd5);

      // Mode 2, timeout in POLL_RESP, then a late response is dropped.
      applyReset(2'd2);
      bootAck = 1'b1;
      rdGnt   = 1'b1;
      stepCycles(101);
      checkOutput("late_tmo", {63'd0, timeoutO}, 64'd1);
      rdRvalid = 1'b1;
      rdRdata  = 32'h1;
      stepCycles(3);
      checkOutput("late_eoc", {63'd0, eocO}, 64'd0);
      checkOutput("late_exit", {32'd0, exitCodeO}, 64'hFFFF_FFFF);
      clearInputs();

      // Mode 3, grant withheld 20 cycles: request and address stay stable.
      begin
         logic gotReq;
         int   stableBad;
         gotReq = 1'b0;
         stableBad = 0;
         applyReset(2'd3);
         bootAck = 1'b1;
         stepCycles(1);
         bootMode = 2'd1;
         for (int c = 0; c < 20; c++) begin
            if (rdReqO) begin
               gotReq = 1'b1;
               break;
            end
            stepCycles(1);
         end
         checkOutput("hold_req_seen", {63'd0, gotReq}, 64'd1);
         for (int c = 0; c < 20; c++) begin
            bootMode = 2'(c);
            if (!rdReqO || (rdAddrO !== SCRATCH)) stableBad++;
            stepCycles(1);
         end
         checkOutput("hold_stable", 64'(stableBad), 64'd0);
         rdGnt = 1'b1;
         stepCycles(1);
         rdGnt = 1'b0;
         checkOutput("hold_req_drop", {63'd0, rdReqO}, 64'd0);
         checkOutput("hold_moderr", {63'd0, modeErrO}, 64'd0);
         clearInputs();
      end

      // Reset during POLL_RESP, stale rvalid with data 1 after release.
      applyReset(2'd2);
      bootAck = 1'b1;
      rdGnt   = 1'b1;
      stepCycles(8);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_busy", {63'd0, busyO}, 64'd1);
      checkOutput("mid_rst_req", {62'd0, bootReqO, rdReqO}, 64'd0);
      stepCycles(1);
      rst      = 1'b0;
      bootAck  = 1'b0;
      rdGnt    = 1'b0;
      rdRvalid = 1'b1;
      rdRdata  = 32'h1;
      stepCycles(1);
      checkOutput("stale_eoc", {63'd0, eocO}, 64'd0);
      checkOutput("stale_bootreq", {63'd0, bootReqO}, 64'd1);
      stepCycles(2);
      checkOutput("stale_eoc2", {63'd0, eocO}, 64'd0);
      clearInputs();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
